// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves forwarded operands, latches the decode bundle
// into the ID/EX register, and owns the load-use interlock and bubble counter.
module id_ex_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  input  logic [WIDTH-1:0]  ID_pc,
  input  logic [WIDTH-1:0]  ID_imm,
  input  logic [WIDTH-1:0]  ID_rs1_data,
  input  logic [WIDTH-1:0]  ID_rs2_data,
  input  logic [4:0]        ID_rd,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic [2:0]        ID_FwdRisk,
  input  logic              ID_MemRead,
  input  logic [1:0]        FwdA,
  input  logic [1:0]        FwdB,
  input  logic [WIDTH-1:0]  EX_result,
  input  logic [WIDTH-1:0]  MEM_result,
  input  logic [WIDTH-1:0]  WB_result,
  input  logic              hold,
  input  logic              flush,
  output logic              EX_valid,
  output logic [WIDTH-1:0]  EX_pc,
  output logic [WIDTH-1:0]  EX_imm,
  output logic [WIDTH-1:0]  EX_opA,
  output logic [WIDTH-1:0]  EX_opB,
  output logic [4:0]        EX_rd,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic [2:0]        EX_FwdRisk,
  output logic              EX_MemRead,
  output logic              stall_ID,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_CAPTURE
  } action_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] opA_next;
  logic [WIDTH-1:0] opB_next;
  logic             load_use;
  action_t          action;

  always_comb begin
    opA_next = ID_rs1_data;
    case (FwdA)
      2'd1:    opA_next = EX_result;
      2'd2:    opA_next = MEM_result;
      2'd3:    opA_next = WB_result;
      default: opA_next = ID_rs1_data;
    endcase
  end

  always_comb begin
    opB_next = ID_rs2_data;
    case (FwdB)
      2'd1:    opB_next = EX_result;
      2'd2:    opB_next = MEM_result;
      2'd3:    opB_next = WB_result;
      default: opB_next = ID_rs2_data;
    endcase
  end

  // A load in EX has no data yet, so an EX-forward from it must wait one cycle.
  assign load_use = EX_valid & EX_MemRead & ID_valid & ((FwdA == 2'd1) | (FwdB == 2'd1));

  always_comb begin
    action = ACT_CAPTURE;
    if (hold)
      action = ACT_HOLD;
    else if (flush)
      action = ACT_FLUSH;
    else if (load_use)
      action = ACT_BUBBLE;
  end

  assign stall_ID = hold | (load_use & ~flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_valid   <= 1'b0;
      EX_pc      <= '0;
      EX_imm     <= '0;
      EX_opA     <= '0;
      EX_opB     <= '0;
      EX_rd      <= '0;
      EX_ctrl    <= '0;
      EX_FwdRisk <= '0;
      EX_MemRead <= 1'b0;
    end else begin
      case (action)
        ACT_HOLD: begin
          EX_valid   <= EX_valid;
          EX_pc      <= EX_pc;
          EX_imm     <= EX_imm;
          EX_opA     <= EX_opA;
          EX_opB     <= EX_opB;
          EX_rd      <= EX_rd;
          EX_ctrl    <= EX_ctrl;
          EX_FwdRisk <= EX_FwdRisk;
          EX_MemRead <= EX_MemRead;
        end
        ACT_FLUSH, ACT_BUBBLE: begin
          EX_valid   <= 1'b0;
          EX_pc      <= '0;
          EX_imm     <= '0;
          EX_opA     <= '0;
          EX_opB     <= '0;
          EX_rd      <= '0;
          EX_ctrl    <= '0;
          EX_FwdRisk <= '0;
          EX_MemRead <= 1'b0;
        end
        default: begin
          // An invalid ID slot still moves data, but its control must not act.
          EX_valid   <= ID_valid;
          EX_pc      <= ID_pc;
          EX_imm     <= ID_imm;
          EX_opA     <= opA_next;
          EX_opB     <= opB_next;
          EX_rd      <= ID_valid ? ID_rd : 5'd0;
          EX_ctrl    <= ID_valid ? ID_ctrl : '0;
          EX_FwdRisk <= ID_valid ? ID_FwdRisk : 3'd0;
          EX_MemRead <= ID_valid & ID_MemRead;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if ((action == ACT_BUBBLE) && (bubble_cnt != '1))
      bubble_cnt <= bubble_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage (CNT_W=4 so the
// bubble counter saturates within a short run).
module tb_id_ex_operand_stage;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ID_valid;
  logic [WIDTH-1:0]  ID_pc, ID_imm, ID_rs1_data, ID_rs2_data;
  logic [4:0]        ID_rd;
  logic [CTRL_W-1:0] ID_ctrl;
  logic [2:0]        ID_FwdRisk;
  logic              ID_MemRead;
  logic [1:0]        FwdA, FwdB;
  logic [WIDTH-1:0]  EX_result, MEM_result, WB_result;
  logic              hold, flush;
  logic              EX_valid;
  logic [WIDTH-1:0]  EX_pc, EX_imm, EX_opA, EX_opB;
  logic [4:0]        EX_rd;
  logic [CTRL_W-1:0] EX_ctrl;
  logic [2:0]        EX_FwdRisk;
  logic              EX_MemRead;
  logic              stall_ID;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_imm(ID_imm),
    .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_rd(ID_rd),
    .ID_ctrl(ID_ctrl), .ID_FwdRisk(ID_FwdRisk), .ID_MemRead(ID_MemRead),
    .FwdA(FwdA), .FwdB(FwdB),
    .EX_result(EX_result), .MEM_result(MEM_result), .WB_result(WB_result),
    .hold(hold), .flush(flush),
    .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_imm(EX_imm),
    .EX_opA(EX_opA), .EX_opB(EX_opB), .EX_rd(EX_rd), .EX_ctrl(EX_ctrl),
    .EX_FwdRisk(EX_FwdRisk), .EX_MemRead(EX_MemRead),
    .stall_ID(stall_ID), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_valid = 1'b0; ID_pc = '0; ID_imm = '0; ID_rs1_data = '0; ID_rs2_data = '0;
    ID_rd = '0; ID_ctrl = '0; ID_FwdRisk = '0; ID_MemRead = 1'b0;
    FwdA = 2'd0; FwdB = 2'd0;
    EX_result = '0; MEM_result = '0; WB_result = '0;
    hold = 1'b0; flush = 1'b0;
  endtask

  // Put a valid load instruction into EX with no forwarding needed.
  task automatic load_a_load();
    ID_valid = 1'b1; ID_MemRead = 1'b1; FwdA = 2'd0; FwdB = 2'd0; ID_rd = 5'd7;
    tick();
    ID_MemRead = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    ID_valid = 1'b1; ID_MemRead = 1'b1; ID_pc = 32'h40; ID_rd = 5'd3;
    ID_ctrl = 16'h1234; ID_FwdRisk = 3'b101; ID_rs1_data = 32'h55;
    tick();
    checks++;
    if (EX_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %0b expected 1", EX_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({EX_valid, EX_pc, EX_imm, EX_opA, EX_opB, EX_rd, EX_ctrl, EX_FwdRisk, EX_MemRead} !== '0) begin
      errors++;
      $display("FAIL async_reset_regs: got valid=%0b pc=%h opA=%h rd=%0d ctrl=%h risk=%0b mr=%0b expected all 0",
               EX_valid, EX_pc, EX_opA, EX_rd, EX_ctrl, EX_FwdRisk, EX_MemRead);
    end
    checks++;
    if (bubble_cnt !== 4'd0) begin
      errors++; $display("FAIL async_reset_cnt: got %0d expected 0", bubble_cnt);
    end
    clear_inputs();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward_mux();
    logic [WIDTH-1:0] exp_a [4];
    exp_a[0] = 32'h11; exp_a[1] = 32'h22; exp_a[2] = 32'h33; exp_a[3] = 32'h44;
    clear_inputs();
    ID_valid = 1'b1; ID_rs1_data = 32'h11; ID_rs2_data = 32'h99;
    EX_result = 32'h22; MEM_result = 32'h33; WB_result = 32'h44;
    for (int i = 0; i < 4; i++) begin
      FwdA = 2'(i);
      FwdB = 2'(3 - i);
      tick();
      checks++;
      if (EX_opA !== exp_a[i]) begin
        errors++; $display("FAIL fwd_opA[%0d]: got %h expected %h", i, EX_opA, exp_a[i]);
      end
      checks++;
      if (EX_opB !== ((i == 3) ? 32'h99 : exp_a[3 - i])) begin
        errors++; $display("FAIL fwd_opB[%0d]: got %h expected %h", i, EX_opB,
                           (i == 3) ? 32'h99 : exp_a[3 - i]);
      end
    end
    checks++;
    if (EX_valid !== 1'b1) begin
      errors++; $display("FAIL fwd_valid: got %0b expected 1", EX_valid);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    load_a_load();
    ID_valid = 1'b1; FwdA = 2'd0; FwdB = 2'd1; EX_result = 32'hBAD0;
    #1;
    checks++;
    if (stall_ID !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %0b expected 1", stall_ID);
    end
    tick();
    checks++;
    if (EX_valid !== 1'b0 || EX_MemRead !== 1'b0 || EX_rd !== 5'd0) begin
      errors++; $display("FAIL lu_bubble: got valid=%0b mr=%0b rd=%0d expected 0/0/0",
                         EX_valid, EX_MemRead, EX_rd);
    end
    checks++;
    if (bubble_cnt !== 4'd1) begin
      errors++; $display("FAIL lu_cnt: got %0d expected 1", bubble_cnt);
    end
    FwdB = 2'd2; MEM_result = 32'hDEAD;
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL lu_release_stall: got %0b expected 0", stall_ID);
    end
    tick();
    checks++;
    if (EX_opB !== 32'hDEAD || EX_valid !== 1'b1) begin
      errors++; $display("FAIL lu_mem_fwd: got opB=%h valid=%0b expected DEAD/1", EX_opB, EX_valid);
    end
  endtask

  task automatic test_flush_beats_load_use();
    clear_inputs();
    load_a_load();
    ID_valid = 1'b1; FwdA = 2'd1; flush = 1'b1;
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %0b expected 0", stall_ID);
    end
    tick();
    checks++;
    if (EX_valid !== 1'b0 || bubble_cnt !== 4'd1) begin
      errors++; $display("FAIL flush_bubble: got valid=%0b cnt=%0d expected 0/1", EX_valid, bubble_cnt);
    end
    flush = 1'b0;
  endtask

  task automatic test_hold();
    clear_inputs();
    ID_valid = 1'b1; ID_pc = 32'h100; ID_rd = 5'd5; ID_ctrl = 16'hABCD; ID_rs1_data = 32'h77;
    tick();
    checks++;
    if (EX_pc !== 32'h100) begin
      errors++; $display("FAIL hold_setup_pc: got %h expected 100", EX_pc);
    end
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ID_pc = 32'h200 + 32'(i); ID_ctrl = 16'h0F0F; ID_rs1_data = 32'h900 + 32'(i);
      #1;
      checks++;
      if (stall_ID !== 1'b1) begin
        errors++; $display("FAIL hold_stall[%0d]: got %0b expected 1", i, stall_ID);
      end
      tick();
      checks++;
      if (EX_pc !== 32'h100 || EX_valid !== 1'b1 || EX_ctrl !== 16'hABCD || EX_opA !== 32'h77 || EX_rd !== 5'd5) begin
        errors++; $display("FAIL hold_frozen[%0d]: got pc=%h valid=%0b ctrl=%h opA=%h rd=%0d expected 100/1/ABCD/77/5",
                           i, EX_pc, EX_valid, EX_ctrl, EX_opA, EX_rd);
      end
    end
    hold = 1'b0;
    #1;
    checks++;
    if (stall_ID !== 1'b0) begin
      errors++; $display("FAIL hold_release_stall: got %0b expected 0", stall_ID);
    end
    tick();
    checks++;
    if (EX_valid !== 1'b0 || EX_ctrl !== 16'h0 || EX_pc !== 32'h0) begin
      errors++; $display("FAIL hold_then_flush: got valid=%0b ctrl=%h pc=%h expected 0/0/0", EX_valid, EX_ctrl, EX_pc);
    end
    flush = 1'b0;
  endtask

  task automatic test_hold_load_use();
    clear_inputs();
    load_a_load();
    ID_valid = 1'b1; FwdA = 2'd1; hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (EX_valid !== 1'b1 || EX_MemRead !== 1'b1 || bubble_cnt !== 4'd1 || stall_ID !== 1'b1) begin
        errors++; $display("FAIL hold_lu[%0d]: got valid=%0b mr=%0b cnt=%0d stall=%0b expected 1/1/1/1",
                           i, EX_valid, EX_MemRead, bubble_cnt, stall_ID);
      end
    end
    hold = 1'b0;
    tick();
    checks++;
    if (EX_valid !== 1'b0 || bubble_cnt !== 4'd2) begin
      errors++; $display("FAIL hold_lu_release: got valid=%0b cnt=%0d expected 0/2", EX_valid, bubble_cnt);
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    for (int i = 0; i < 20; i++) begin
      load_a_load();
      ID_valid = 1'b1; FwdB = 2'd1;
      tick();
      FwdB = 2'd0;
      if (i == 12) begin
        checks++;
        if (bubble_cnt !== 4'd15) begin
          errors++; $display("FAIL sat_reach: got %0d expected 15", bubble_cnt);
        end
      end
    end
    checks++;
    if (bubble_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_hold: got %0d expected 15", bubble_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forward_mux();
    test_load_use();
    test_flush_beats_load_use();
    test_hold();
    test_hold_load_use();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Sits between decode and execute. Consumes the 2-bit forwarding selects FwdA/FwdB from the forwarding unit.
- Resolves each source operand from one of four places: the register file, the EX result, the MEM result or the WB result.
- Latches the resolved operands, plus the decode bundle, into the ID/EX pipeline register.
- Owns the load-use interlock: inserts one bubble and stalls fetch/decode when a load in EX feeds the instruction in ID. Also handles pipeline hold, branch flush and a bubble performance counter.

Parameters:
WIDTH, 32, datapath/operand width
CTRL_W, 16, width of opaque decode control bundle passed through to EX
CNT_W, 16, width of saturating bubble counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_valid  input  1  ID holds a real instruction
ID_pc  input  WIDTH  PC of ID instruction
ID_imm  input  WIDTH  decoded immediate
ID_rs1_data  input  WIDTH  register file read port 1
ID_rs2_data  input  WIDTH  register file read port 2
ID_rd  input  5  destination register
ID_ctrl  input  CTRL_W  decode control bundle
ID_FwdRisk  input  3  forwarding-risk flags of ID instruction
ID_MemRead  input  1  ID instruction is a load
FwdA  input  2  rs1 source select: 0 RF, 1 EX, 2 MEM, 3 WB
FwdB  input  2  rs2 source select, same encoding
EX_result  input  WIDTH  EX-stage ALU result (combinational)
MEM_result  input  WIDTH  MEM-stage writeback value (load data or ALU result)
WB_result  input  WIDTH  WB-stage writeback value
hold  input  1  downstream stall; freeze ID/EX register
flush  input  1  branch/jump redirect; kill ID instruction
EX_valid  output  1  registered valid
EX_pc  output  WIDTH  registered PC
EX_imm  output  WIDTH  registered immediate
EX_opA  output  WIDTH  registered resolved rs1 operand
EX_opB  output  WIDTH  registered resolved rs2 operand
EX_rd  output  5  registered destination
EX_ctrl  output  CTRL_W  registered control bundle
EX_FwdRisk  output  3  registered forwarding-risk flags
EX_MemRead  output  1  registered load flag
stall_ID  output  1  combinational; hold PC and IF/ID register this cycle
bubble_cnt  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including EX_valid, EX_opA/B, EX_rd, EX_ctrl, EX_FwdRisk, EX_MemRead and bubble_cnt. A reset mid-stall discards the stalled state.
- Operand mux, combinational: opA_next = FwdA ? {EX_result, MEM_result, WB_result}[FwdA-1] : ID_rs1_data. opB_next is the same with FwdB.
- load_use = EX_valid & EX_MemRead & ID_valid & (FwdA==1 | FwdB==1). Load data is not available from EX.
- Register update priority, one decision per rising edge:
  1. hold=1: all EX_* keep their value. stall_ID=1. flush is not consumed; the source keeps flush asserted until hold drops.
  2. flush=1: load a bubble. EX_valid=0, EX_ctrl=0, EX_rd=0, EX_FwdRisk=0, EX_MemRead=0; data fields don't-care but driven to 0. stall_ID=0. Flush overrides load_use, so no bubble count.
  3. load_use=1: load a bubble, as for flush. stall_ID=1. bubble_cnt increments.
  4. Otherwise: capture ID_* and opA_next/opB_next. EX_valid=ID_valid. stall_ID=0.
- ID_valid=0 in the normal case: capture as a bubble. EX_valid=0 and all control fields 0.
- stall_ID = hold | (load_use & ~flush). It is purely combinational and has no registered lag.
- Load-use latency: exactly one bubble per load-use pair. On the next cycle the load is in MEM, the forwarding unit reports 2, and the ID instruction captures MEM_result.
- Both operands dependent on the same EX load: still one bubble.
- bubble_cnt saturates at all-ones and does not wrap. It does not increment while hold=1.
- Operand width: all muxes are full WIDTH with no extension. rd=0 protection belongs to the forwarding unit; FwdA/FwdB are applied as given.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with EX_valid=1 -> all outputs 0 immediately, before any clock edge; bubble_cnt=0.
- Forward mux: ID_rs1_data=0x11, EX/MEM/WB_result=0x22/0x33/0x44, FwdA cycled 0..3 with no load in EX -> EX_opA = 0x11, 0x22, 0x33, 0x44 on successive edges.
- Load-use: EX_MemRead=1, EX_valid=1, FwdB=1 -> stall_ID=1, next EX_valid=0, bubble_cnt=1. Next cycle FwdB=2, MEM_result=0xDEAD -> EX_opB=0xDEAD, EX_valid=1.
- Flush beats load-use: load_use and flush both true -> EX_valid=0, stall_ID=0, bubble_cnt unchanged.
- Hold: EX holds pc=0x100; hold=1 for 3 cycles with flush=1 and changing ID inputs -> EX_* stays constant, stall_ID=1. Hold drops with flush still asserted -> bubble loaded.
- Saturation: CNT_W=4, force 20 load-use events -> bubble_cnt stops at 15.
